step_sequencer_ctrl: RTL and testbench
======================================

Name: step_sequencer_ctrl

Overview:
Transport and pattern controller that sequences the tempo step counter.
- Owns play/pause/stop state, current tempo, step pointer and a NUM_TRACKS x NUM_STEPS on/off pattern.
- Drives the tempo counter's nStart and BPM inputs and consumes its Step pulse.
- Produces per-track one-cycle triggers and timed gates for the sound/LED blocks downstream.

Parameters:
NUM_STEPS, 16, steps per pattern (power of two, 2..64)
NUM_TRACKS, 4, independent pattern rows
GATE_CYCLES, 2_500_000, gate length in Clock cycles (50 ms at 50 MHz)
BPM_MIN, 30, lowest tempo
BPM_MAX, 300, highest tempo
BPM_DEFAULT, 120, tempo after reset

Ports:
Clock  in  1  system clock, 50 MHz
nReset  in  1  synchronous active-low reset
PlayPause  in  1  one-cycle pulse: play from IDLE/PAUSE, pause from PLAY
Stop  in  1  one-cycle pulse: return to IDLE, rewind
TempoUp  in  1  one-cycle pulse: BPM +1
TempoDown  in  1  one-cycle pulse: BPM -1
EditToggle  in  1  one-cycle pulse: invert pattern bit [EditTrack][EditStep]
EditTrack  in  clog2(NUM_TRACKS)  edit row
EditStep  in  clog2(NUM_STEPS)  edit column
StepTick  in  1  Step pulse from tempo counter
nStartOut  out  1  active-low start to tempo counter
BPM  out  10  current tempo to tempo counter
StepIndex  out  clog2(NUM_STEPS)  step currently sounding
Playing  out  1  high in ARM or PLAY
Trig  out  NUM_TRACKS  one-cycle trigger per track
Gate  out  NUM_TRACKS  per-track gate, GATE_CYCLES long

Behaviour:
- Reset values:
  - state IDLE; nStartOut=1; BPM=BPM_DEFAULT; StepIndex=0; NextPtr=0.
  - Playing=0; Trig=0; Gate=0; all gate counters 0; pattern all 0.
  - Reset mid-play behaves identically; no trigger is emitted on the reset cycle.
- States:
  - IDLE: PlayPause -> ARM.
  - ARM: drive nStartOut=0 for exactly one cycle, then -> PLAY unconditionally. The tempo counter latches its target and emits Step on the following cycle.
  - PLAY: PlayPause -> PAUSE; Stop -> IDLE.
  - PAUSE: PlayPause -> ARM (resume); Stop -> IDLE.
- Event priority: Stop has priority over PlayPause in the same cycle, in every state.
- Stop, or entry to IDLE:
  - NextPtr=0, StepIndex=0, Trig=0, all Gate cleared on the next cycle.
  - Pattern and BPM are retained.
- Pause: NextPtr, StepIndex and Gate counters freeze; Gate outputs drop to 0. A resume retriggers through ARM from NextPtr.
- StepTick in PLAY, all updates registered, 1-cycle latency:
  - StepIndex <= NextPtr.
  - Trig[t] <= pattern[t][NextPtr].
  - NextPtr <= NextPtr+1, wrapping NUM_STEPS-1 -> 0.
  - For each t with the bit set, reload that track's gate counter to GATE_CYCLES.
- StepTick outside PLAY (IDLE, ARM, PAUSE) is ignored.
- Trig is high for exactly one cycle per accepted tick. It is 0 on all other cycles.
- Gate[t] is high while counter[t] != 0. The counter decrements once per cycle in PLAY. A retrigger while still high reloads without a low cycle.
- Tempo arithmetic:
  - TempoUp: BPM+1, saturating at BPM_MAX. TempoDown: BPM-1, saturating at BPM_MIN.
  - Both in the same cycle: no change.
  - BPM output updates 1 cycle after the pulse, in any state.
  - The tempo counter samples BPM only at nStart, so a change made while in PLAY takes effect at the next ARM. No re-arm is issued mid-play.
- Edit:
  - EditToggle is accepted in any state; the bit is inverted on the next clock.
  - If EditToggle targets NextPtr on the same cycle as an accepted StepTick, Trig uses the pre-toggle bit (read-before-write).
- Widths: BPM is 10 bits and must hold BPM_MAX ≤ 1023. Gate counters are clog2(GATE_CYCLES+1) bits.

Decomposition:
- Shared package seq_pkg holds:
  - state encoding: IDLE=2'd0, ARM=2'd1, PLAY=2'd2, PAUSE=2'd3;
  - BPM_MIN, BPM_MAX, BPM_DEFAULT, CLK_HZ=50_000_000, default GATE_CYCLES;
  - the step/track index width constants.
- Sub-module gate_timer holds one loadable down-counter with Load, Run and Clear inputs and a Gate output. It is instantiated NUM_TRACKS times.
- The FSM, tempo register and pattern array stay in the top.

Test Plan:
- Reset -> PlayPause -> nStartOut low 1 cycle (cycle 2), Playing=1; emulated StepTick one cycle after nStart, pattern[0][0]=1 -> Trig=4'b0001, StepIndex=0, Gate[0] high GATE_CYCLES (override 8) cycles.
- Pattern track1 steps {0,4,8,12}; 17 StepTicks in PLAY -> Trig[1] at ticks 1,5,9,13,17; StepIndex wraps 15->0 at tick 17.
- Mid-play PlayPause after 5 ticks, 3 StepTicks while paused, then PlayPause -> Trig silent in pause, new nStart pulse, next tick StepIndex=5.
- Stop and PlayPause same cycle during PLAY -> state IDLE, StepIndex=0, Gate=0, Playing=0; pattern preserved (readback by replay).
- 200 TempoUp pulses from 120 -> BPM=300 saturated; 300 TempoDown -> BPM=30; simultaneous Up+Down -> unchanged.
- EditToggle on step 3 in the same cycle as tick playing step 3 (bit was 0) -> Trig=0 that tick, Trig asserted on step 3 after wrap; nReset low during a gate -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the step sequencer: transport state encoding,
// tempo limits and default sizing used by the controller and its gate timers.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    PLAY  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEF_BPM_MIN     = 30;
  localparam int DEF_BPM_MAX     = 300;
  localparam int DEF_BPM         = 120;
  localparam int DEF_GATE_CYCLES = 2_500_000;
  localparam int DEF_NUM_STEPS   = 16;
  localparam int DEF_NUM_TRACKS  = 4;
  localparam int STEP_W          = $clog2(DEF_NUM_STEPS);
  localparam int TRACK_W         = $clog2(DEF_NUM_TRACKS);

endpackage

// File: rtl/gate_timer.sv
// One loadable down-counter per track; Gate stays high while the count is
// nonzero, and Run lets the owner freeze the count outside playback.
module gate_timer #(
  parameter int  GATE_CYCLES = seq_pkg::DEF_GATE_CYCLES,
  localparam int CW          = $clog2(GATE_CYCLES + 1)
) (
  input  logic Clock,
  input  logic nReset,
  input  logic Load,
  input  logic Run,
  input  logic Clear,
  output logic Gate
);

  logic [CW-1:0] count;

  // Load beats decrement so a retrigger while high reloads without a low cycle
  always_ff @(posedge Clock) begin
    if (!nReset || Clear)
      count <= '0;
    else if (Load)
      count <= CW'(GATE_CYCLES);
    else if (Run && count != '0)
      count <= count - 1'b1;
  end

  assign Gate = (count != '0);

endmodule

// File: rtl/step_sequencer_ctrl.sv
// Transport and pattern controller: arms the external tempo counter and turns
// its Step pulses into per-track triggers and timed gates.
module step_sequencer_ctrl
  import seq_pkg::*;
#(
  parameter int  NUM_STEPS   = DEF_NUM_STEPS,
  parameter int  NUM_TRACKS  = DEF_NUM_TRACKS,
  parameter int  GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int  BPM_MIN     = DEF_BPM_MIN,
  parameter int  BPM_MAX     = DEF_BPM_MAX,
  parameter int  BPM_DEFAULT = DEF_BPM,
  localparam int SW          = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int TW          = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  PlayPause,
  input  logic                  Stop,
  input  logic                  TempoUp,
  input  logic                  TempoDown,
  input  logic                  EditToggle,
  input  logic [TW-1:0]         EditTrack,
  input  logic [SW-1:0]         EditStep,
  input  logic                  StepTick,
  output logic                  nStartOut,
  output logic [9:0]            BPM,
  output logic [SW-1:0]         StepIndex,
  output logic                  Playing,
  output logic [NUM_TRACKS-1:0] Trig,
  output logic [NUM_TRACKS-1:0] Gate
);

  localparam logic [9:0] BMIN = 10'(BPM_MIN);
  localparam logic [9:0] BMAX = 10'(BPM_MAX);
  localparam logic [9:0] BDEF = 10'(BPM_DEFAULT);

  state_t                state, state_nxt;
  logic [SW-1:0]         next_ptr;
  logic [NUM_STEPS-1:0]  pattern [NUM_TRACKS];
  logic [NUM_TRACKS-1:0] column;
  logic [NUM_TRACKS-1:0] gate_raw;
  logic                  accept;

  always_ff @(posedge Clock) begin
    if (!nReset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Stop overrides whatever the transport case decided, including in ARM
  always_comb begin
    state_nxt = state;
    nStartOut = 1'b1;
    Playing   = 1'b0;
    case (state)
      IDLE:    if (PlayPause) state_nxt = ARM;
      ARM: begin
        nStartOut = 1'b0;
        Playing   = 1'b1;
        state_nxt = PLAY;
      end
      PLAY: begin
        Playing = 1'b1;
        if (PlayPause) state_nxt = PAUSE;
      end
      PAUSE:   if (PlayPause) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
    if (Stop) state_nxt = IDLE;
  end

  assign accept = (state == PLAY) && StepTick && !Stop;

  always_comb begin
    column = '0;
    for (int t = 0; t < NUM_TRACKS; t++)
      column[t] = pattern[t][next_ptr];
  end

  always_ff @(posedge Clock) begin
    if (!nReset || Stop) begin
      next_ptr  <= '0;
      StepIndex <= '0;
      Trig      <= '0;
    end else if (accept) begin
      StepIndex <= next_ptr;
      Trig      <= column;
      next_ptr  <= next_ptr + 1'b1;
    end else begin
      Trig <= '0;
    end
  end

  // Trig reads the column combinationally, so a same-cycle toggle is seen next pass
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int t = 0; t < NUM_TRACKS; t++)
        pattern[t] <= '0;
    end else if (EditToggle) begin
      pattern[EditTrack][EditStep] <= ~pattern[EditTrack][EditStep];
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset)
      BPM <= BDEF;
    else if (TempoUp && !TempoDown && BPM < BMAX)
      BPM <= BPM + 10'd1;
    else if (TempoDown && !TempoUp && BPM > BMIN)
      BPM <= BPM - 10'd1;
  end

  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_gate
    gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_gate (
      .Clock (Clock),
      .nReset(nReset),
      .Load  (accept && column[t]),
      .Run   (state == PLAY),
      .Clear (Stop),
      .Gate  (gate_raw[t])
    );
  end

  // Counters keep their value across a pause; only the visible gate is muted
  assign Gate = (state == PAUSE) ? '0 : gate_raw;

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Directed bench for step_sequencer_ctrl: trigger events go through a
// scoreboard queue drained by a monitor, other outputs are checked in place.
module tb_step_sequencer_ctrl;

  localparam int NS = 16;
  localparam int NT = 4;
  localparam int GC = 8;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       PlayPause = 1'b0, Stop = 1'b0, TempoUp = 1'b0, TempoDown = 1'b0;
  logic       EditToggle = 1'b0, StepTick = 1'b0;
  logic [1:0] EditTrack = 2'd0;
  logic [3:0] EditStep = 4'd0;
  logic       nStartOut;
  logic [9:0] BPM;
  logic [3:0] StepIndex;
  logic       Playing;
  logic [3:0] Trig;
  logic [3:0] Gate;

  typedef struct {
    logic [3:0] trig;
    logic [3:0] idx;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] model[NT];
  int          mptr = 0;
  int          checks = 0;
  int          errors = 0;

  step_sequencer_ctrl #(.GATE_CYCLES(GC)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .PlayPause (PlayPause),
    .Stop      (Stop),
    .TempoUp   (TempoUp),
    .TempoDown (TempoDown),
    .EditToggle(EditToggle),
    .EditTrack (EditTrack),
    .EditStep  (EditStep),
    .StepTick  (StepTick),
    .nStartOut (nStartOut),
    .BPM       (BPM),
    .StepIndex (StepIndex),
    .Playing   (Playing),
    .Trig      (Trig),
    .Gate      (Gate)
  );

  always #10 Clock = ~Clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs starting at a falling edge, then returns them to idle
  task automatic applyStimulus(input logic pp, input logic st, input logic up, input logic dn,
                               input logic ed, input logic [1:0] et, input logic [3:0] es,
                               input logic tk);
    PlayPause  = pp;
    Stop       = st;
    TempoUp    = up;
    TempoDown  = dn;
    EditToggle = ed;
    EditTrack  = et;
    EditStep   = es;
    StepTick   = tk;
    @(negedge Clock);
    PlayPause  = 1'b0;
    Stop       = 1'b0;
    TempoUp    = 1'b0;
    TempoDown  = 1'b0;
    EditToggle = 1'b0;
    StepTick   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic pressPlay();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic pressStop();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    mptr = 0;
  endtask

  task automatic doEdit(input logic [1:0] t, input logic [3:0] s);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t, s, 1'b0);
    model[t][s] = ~model[t][s];
  endtask

  function automatic logic [3:0] colAt(input int p);
    logic [3:0] c;
    for (int t = 0; t < NT; t++) c[t] = model[t][p];
    return c;
  endfunction

  // One accepted tick: nonzero columns are queued for the monitor
  task automatic doTick();
    logic [3:0] c;
    c = colAt(mptr);
    if (c != 4'd0) expQ.push_back('{trig: c, idx: 4'(mptr)});
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    checkOutput("tick_step_index", StepIndex, mptr);
    if (c == 4'd0) checkOutput("tick_trig_silent", Trig, 0);
    mptr = (mptr + 1) % NS;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (nReset && Trig != 4'd0) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL trig_unexpected: got Trig=%b at StepIndex=%0d, expected no trigger",
                   Trig, StepIndex);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_trig", Trig, e.trig);
          checkOutput("sb_index", StepIndex, e.idx);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: end of test not reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int t = 0; t < NT; t++) model[t] = 16'd0;
    repeat (3) @(negedge Clock);
    nReset = 1'b1;
    checkOutput("rst_nstart", nStartOut, 1);
    checkOutput("rst_bpm", BPM, 120);
    checkOutput("rst_step_index", StepIndex, 0);
    checkOutput("rst_playing", Playing, 0);
    checkOutput("rst_trig", Trig, 0);
    checkOutput("rst_gate", Gate, 0);

    $display("[TB] first play: arm pulse, trigger and gate length");
    doEdit(2'd0, 4'd0);
    pressPlay();
    checkOutput("arm_nstart_low", nStartOut, 0);
    checkOutput("arm_playing", Playing, 1);
    idle(1);
    checkOutput("play_nstart_high", nStartOut, 1);
    checkOutput("play_playing", Playing, 1);
    doTick();
    for (int i = 0; i < GC + 2; i++) begin
      checkOutput("gate0_length", Gate, (i < GC) ? 1 : 0);
      idle(1);
      if (i == 0) checkOutput("trig_one_cycle", Trig, 0);
    end
    pressStop();
    checkOutput("stop_index", StepIndex, 0);
    checkOutput("stop_playing", Playing, 0);

    $display("[TB] track 1 every fourth step, 17 ticks with wrap");
    doEdit(2'd1, 4'd0);
    doEdit(2'd1, 4'd4);
    doEdit(2'd1, 4'd8);
    doEdit(2'd1, 4'd12);
    pressPlay();
    idle(1);
    for (int k = 1; k <= 17; k++) begin
      doTick();
      if (k == 16) checkOutput("last_step_index", StepIndex, 15);
      if (k == 17) checkOutput("wrap_step_index", StepIndex, 0);
      idle(1);
    end

    $display("[TB] stop and play together while playing");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    mptr = 0;
    checkOutput("stopplay_playing", Playing, 0);
    checkOutput("stopplay_index", StepIndex, 0);
    checkOutput("stopplay_gate", Gate, 0);
    checkOutput("stopplay_nstart", nStartOut, 1);
    idle(1);
    checkOutput("stopplay_stays_idle", Playing, 0);

    $display("[TB] pause after five ticks, ticks ignored, resume from step 5");
    pressPlay();
    idle(1);
    for (int k = 0; k < 5; k++) begin
      doTick();
      idle(1);
    end
    pressPlay();
    checkOutput("pause_playing", Playing, 0);
    checkOutput("pause_gate_muted", Gate, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
      checkOutput("pause_trig", Trig, 0);
      checkOutput("pause_index_frozen", StepIndex, 4);
    end
    pressPlay();
    checkOutput("resume_nstart_low", nStartOut, 0);
    checkOutput("resume_gate_frozen", Gate, 4'b0010);
    idle(1);
    doTick();
    checkOutput("resume_index", StepIndex, 5);

    $display("[TB] tempo saturation");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    checkOutput("bpm_first_up", BPM, 121);
    repeat (199) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    checkOutput("bpm_max", BPM, 300);
    checkOutput("no_rearm_in_play", nStartOut, 1);
    repeat (300) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    checkOutput("bpm_min", BPM, 30);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    checkOutput("bpm_after_ups", BPM, 35);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    checkOutput("bpm_up_down", BPM, 35);

    $display("[TB] edit on the step being played, then reset during a gate");
    pressStop();
    pressPlay();
    idle(1);
    for (int k = 0; k < 3; k++) begin
      doTick();
      idle(1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd3, 1'b1);
    checkOutput("edit_rbw_trig", Trig, 0);
    checkOutput("edit_rbw_index", StepIndex, 3);
    model[2][3] = 1'b1;
    mptr = 4;
    idle(1);
    for (int k = 0; k < 15; k++) begin
      doTick();
      idle(1);
    end
    doTick();
    checkOutput("edit_trig_after_wrap", Trig, 4'b0100);
    checkOutput("edit_gate_high", Gate[2], 1);
    nReset = 1'b0;
    @(negedge Clock);
    checkOutput("midrst_nstart", nStartOut, 1);
    checkOutput("midrst_bpm", BPM, 120);
    checkOutput("midrst_index", StepIndex, 0);
    checkOutput("midrst_playing", Playing, 0);
    checkOutput("midrst_trig", Trig, 0);
    checkOutput("midrst_gate", Gate, 0);
    nReset = 1'b1;
    mptr = 0;
    for (int t = 0; t < NT; t++) model[t] = 16'd0;
    pressPlay();
    idle(1);
    doTick();

    idle(2);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
